// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed at issue and committed after a fixed busy window.
//
// state  | meaning
// S_IDLE | ready to accept; busy low
// S_RUN  | result held internally, counting down the busy window
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic [WIDTH-1:0]         res_hi;
  logic [WIDTH-1:0]         res_lo;
  logic                     res_commit;

  logic signed [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0]        prod_u;
  logic [WIDTH-1:0]          dsor_s;
  logic [WIDTH-1:0]          dsor_u;
  logic signed [WIDTH-1:0]   quo_s;
  logic signed [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]          quo_u;
  logic [WIDTH-1:0]          rem_u;
  logic                      div_zero;

  always_comb begin
    prod_s   = $signed({{WIDTH{op1[WIDTH-1]}}, op1}) * $signed({{WIDTH{op2[WIDTH-1]}}, op2});
    prod_u   = {{WIDTH{1'b0}}, op1} * {{WIDTH{1'b0}}, op2};
    div_zero = (op2 == '0);
    dsor_u   = div_zero ? ONE : op2;
    // Dividing the most-negative value by 1 instead of -1 yields exactly the
    // required overflow result (quotient = most-negative, remainder = 0).
    dsor_s   = (div_zero || (op1 == MOST_NEG && op2 == '1)) ? ONE : op2;
    quo_s    = $signed(op1) / $signed(dsor_s);
    rem_s    = $signed(op1) % $signed(dsor_s);
    quo_u    = op1 / dsor_u;
    rem_u    = op1 % dsor_u;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      res_hi     <= '0;
      res_lo     <= '0;
      res_commit <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT: begin
                res_hi     <= prod_s[2*WIDTH-1:WIDTH];
                res_lo     <= prod_s[WIDTH-1:0];
                res_commit <= 1'b1;
                cnt        <= MULT_N;
                busy       <= 1'b1;
                state      <= S_RUN;
              end
              OP_MULTU: begin
                res_hi     <= prod_u[2*WIDTH-1:WIDTH];
                res_lo     <= prod_u[WIDTH-1:0];
                res_commit <= 1'b1;
                cnt        <= MULT_N;
                busy       <= 1'b1;
                state      <= S_RUN;
              end
              OP_DIV: begin
                res_hi     <= rem_s;
                res_lo     <= quo_s;
                res_commit <= !div_zero;
                cnt        <= DIV_N;
                busy       <= 1'b1;
                state      <= S_RUN;
              end
              OP_DIVU: begin
                res_hi     <= rem_u;
                res_lo     <= quo_u;
                res_commit <= !div_zero;
                cnt        <= DIV_N;
                busy       <= 1'b1;
                state      <= S_RUN;
              end
              OP_MTHI: hi <= op1;
              OP_MTLO: lo <= op1;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (cnt == CNT_ONE) begin
            if (res_commit) begin
              hi <= res_hi;
              lo <= res_lo;
            end
            cnt   <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: a 32-bit default instance and an 8-bit fast instance,
// checked against an arithmetic reference model of HI/LO.
module tb_md_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_a, busy_a;
  logic [2:0]  op_a;
  logic [31:0] op1_a, op2_a, hi_a, lo_a;
  logic        start_b, busy_b;
  logic [2:0]  op_b;
  logic [7:0]  op1_b, op2_b, hi_b, lo_b;

  md_unit dut_a (
    .clk(clk), .reset(reset), .start(start_a), .op(op_a), .op1(op1_a), .op2(op2_a),
    .busy(busy_a), .hi(hi_a), .lo(lo_a)
  );

  md_unit #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .op(op_b), .op1(op1_b), .op2(op2_b),
    .busy(busy_b), .hi(hi_b), .lo(lo_b)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] mh [2];
  logic [31:0] ml [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sext(input logic [31:0] v, input int w);
    longint x;
    x = longint'({32'b0, v});
    if (v[w-1]) x = x - (64'sd1 <<< w);
    return x;
  endfunction

  // Architectural effect of one accepted op on the HI/LO model.
  function automatic void ref_op(input int o, input logic [31:0] a, input logic [31:0] b,
                                 input int w, inout logic [31:0] h, inout logic [31:0] l);
    longint sa, sb, p, q, r;
    logic [63:0] up;
    logic [31:0] m;
    m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    sa = sext(a, w);
    sb = sext(b, w);
    case (o)
      1: begin p = sa * sb; h = 32'(p >>> w) & m; l = 32'(p) & m; end
      2: begin up = {32'b0, a} * {32'b0, b}; h = 32'(up >> w) & m; l = 32'(up) & m; end
      3: if (b != 0) begin q = sa / sb; r = sa % sb; l = 32'(q) & m; h = 32'(r) & m; end
      4: if (b != 0) begin l = a / b; h = a % b; end
      5: h = a;
      6: l = a;
      default: ;
    endcase
  endfunction

  task automatic drive(input int d, input logic s, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    if (d == 0) begin
      start_a = s; op_a = o; op1_a = a; op2_a = b;
    end else begin
      start_b = s; op_b = o; op1_b = a[7:0]; op2_b = b[7:0];
    end
  endtask

  function automatic logic obs_busy(input int d);
    return (d == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic [31:0] obs_hi(input int d);
    return (d == 0) ? hi_a : {24'b0, hi_b};
  endfunction
  function automatic logic [31:0] obs_lo(input int d);
    return (d == 0) ? lo_a : {24'b0, lo_b};
  endfunction

  // Issue one op and check busy / HI / LO every cycle until it is architecturally done.
  // With poke set, an MTHI of 0xAA is attempted throughout the busy window.
  task automatic run_op(input int d, input int o, input logic [31:0] a, input logic [31:0] b,
                        input bit poke);
    logic [31:0] nh, nl;
    int n, w;
    string t;
    w = (d == 0) ? 32 : 8;
    if (w == 8) begin a = a & 32'hFF; b = b & 32'hFF; end
    nh = mh[d];
    nl = ml[d];
    ref_op(o, a, b, w, nh, nl);
    n = (o == 1 || o == 2) ? ((d == 0) ? 5 : 1) :
        (o == 3 || o == 4) ? ((d == 0) ? 10 : 3) : 0;
    t = $sformatf("d%0d op%0d %0h,%0h", d, o, a, b);
    @(negedge clk);
    drive(d, 1'b1, 3'(o), a, b);
    @(negedge clk);
    for (int i = 1; i <= n; i++) begin
      if (poke) drive(d, 1'b1, 3'd5, 32'hAA, $urandom);
      else      drive(d, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
      check({t, $sformatf(" busy@%0d", i)}, obs_busy(d), 1'b1);
      check({t, $sformatf(" hi hold@%0d", i)}, obs_hi(d), mh[d]);
      check({t, $sformatf(" lo hold@%0d", i)}, obs_lo(d), ml[d]);
      @(negedge clk);
    end
    drive(d, 1'b0, 3'd0, 32'h0, 32'h0);
    check({t, " busy done"}, obs_busy(d), 1'b0);
    check({t, " hi"}, obs_hi(d), nh);
    check({t, " lo"}, obs_lo(d), nl);
    mh[d] = nh;
    ml[d] = nl;
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return m;
      2:       return 32'd1 << (w - 1);
      3:       return 32'd1;
      default: return $urandom & m;
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    drive(0, 1'b1, 3'd1, 32'h1234_5678, 32'h9);
    drive(1, 1'b1, 3'd1, 32'h37, 32'h5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst busy_a", busy_a, 1'b0);
    check("rst hi_a", hi_a, 32'h0);
    check("rst lo_a", lo_a, 32'h0);
    check("rst busy_b", busy_b, 1'b0);
    check("rst hi_b", hi_b, 8'h0);
    check("rst lo_b", lo_b, 8'h0);
    drive(0, 1'b0, 3'd0, 32'h0, 32'h0);
    drive(1, 1'b0, 3'd0, 32'h0, 32'h0);
    reset = 1'b1;
    mh = '{32'h0, 32'h0};
    ml = '{32'h0, 32'h0};

    run_op(0, 1, 32'hFFFF_FFFE, 32'h3, 0);
    check("mult -2*3 hi", hi_a, 32'hFFFF_FFFF);
    check("mult -2*3 lo", lo_a, 32'hFFFF_FFFA);
    run_op(0, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu hi", hi_a, 32'hFFFF_FFFE);
    check("multu lo", lo_a, 32'h0000_0001);
    run_op(0, 3, 32'hFFFF_FFF9, 32'h2, 0);
    check("div -7/2 lo", lo_a, 32'hFFFF_FFFD);
    check("div -7/2 hi", hi_a, 32'hFFFF_FFFF);
    run_op(0, 4, 32'hFFFF_FFF9, 32'h2, 0);
    check("divu lo", lo_a, 32'h7FFF_FFFC);
    check("divu hi", hi_a, 32'h1);
    run_op(0, 3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div ovf lo", lo_a, 32'h8000_0000);
    check("div ovf hi", hi_a, 32'h0);
    run_op(0, 5, 32'h11, 32'h0, 0);
    run_op(0, 6, 32'h22, 32'h0, 0);
    run_op(0, 4, 32'hDEAD_BEEF, 32'h0, 0);
    check("divu /0 hi", hi_a, 32'h11);
    check("divu /0 lo", lo_a, 32'h22);
    run_op(0, 1, 32'h7, 32'h9, 1);
    check("mthi ignored while busy", hi_a, 32'h0);
    run_op(0, 6, 32'h1234, 32'h0, 0);
    check("mtlo lo", lo_a, 32'h1234);
    run_op(0, 0, 32'h5555, 32'h3, 0);
    run_op(0, 7, 32'h5555, 32'h3, 0);

    run_op(1, 1, 32'hFE, 32'h03, 0);
    check("w8 mult hi", hi_b, 8'hFF);
    check("w8 mult lo", lo_b, 8'hFA);
    run_op(1, 3, 32'h80, 32'hFF, 0);

    // Reset in the middle of a MULT: no commit may follow.
    run_op(0, 5, 32'hDEAD, 32'h0, 0);
    @(negedge clk);
    drive(0, 1'b1, 3'd1, 32'h5, 32'h6);
    @(negedge clk);
    drive(0, 1'b0, 3'd0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midrst busy", busy_a, 1'b0);
    check("midrst hi", hi_a, 32'h0);
    check("midrst lo", lo_a, 32'h0);
    repeat (8) @(negedge clk);
    check("midrst no commit busy", busy_a, 1'b0);
    check("midrst no commit hi", hi_a, 32'h0);
    check("midrst no commit lo", lo_a, 32'h0);
    mh = '{32'h0, 32'h0};
    ml = '{32'h0, 32'h0};

    for (int k = 0; k < 60; k++) begin
      int d;
      d = $urandom_range(0, 1);
      run_op(d, $urandom_range(0, 7), pick(d ? 8 : 32), pick(d ? 8 : 32),
             $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits in the EX stage beside the combinational ALU and serves MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Asserts busy for a configurable latency so the hazard unit can stall MFHI/MFLO and further MD ops.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (>=2).
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  issue strobe; op/op1/op2 are sampled on the edge where start=1 and busy=0.
- op  input  3  1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO; 0 and 7 are no-op.
- op1  input  WIDTH  rs operand (dividend / multiplicand / MT source).
- op2  input  WIDTH  rt operand (divisor / multiplier).
- busy  output  1  high while an operation is in flight.
- hi  output  WIDTH  HI register (registered).
- lo  output  WIDTH  LO register (registered).

Behaviour:
- Reset: sampled on the rising edge while reset=0. Clears hi, lo, busy, cycle counter and all latched operands/results to 0. Reset aborts any in-flight op; no commit follows.
- Accept condition: start=1, busy=0, op in 1..6. Any other start (busy=1 or op 0/7) is ignored with no state change.
- MTHI/MTLO:
  - hi (or lo) <= op1 on the accept edge.
  - busy stays 0; visible the next cycle.
  - The other register is unchanged.
- MULT/MULTU/DIV/DIVU:
  - On the accept edge, the full result is computed from op1/op2 and held in internal result registers.
  - The counter loads N = MULT_CYCLES or DIV_CYCLES.
  - busy = (counter != 0), so busy is high for exactly N cycles starting the cycle after accept.
  - The counter decrements each cycle. On the edge where counter == 1, hi/lo commit and counter goes to 0.
  - Issue edge T: busy high T+1..T+N; new hi/lo and busy=0 both visible from cycle T+N+1.
  - hi/lo hold their old values throughout busy.
- Multiply:
  - Full 2*WIDTH-bit product; hi = upper WIDTH bits, lo = lower WIDTH bits.
  - MULT treats operands as two's-complement; MULTU as unsigned.
- Divide:
  - lo = quotient, hi = remainder.
  - DIV truncates toward zero; a nonzero remainder takes the sign of the dividend. DIVU is unsigned.
  - Overflow (DIV, op1 = most-negative, op2 = -1): lo = most-negative, hi = 0.
  - Divide by zero (either variant): the op still occupies N busy cycles; hi and lo are left unchanged at commit.
- Back-to-back: a new start is accepted on the first edge where busy=0, i.e. cycle T+N+1 at the earliest. No queueing.
- No-op codes 0 and 7 never assert busy.

Test Plan:
- Reset: hold reset=0 for 2 cycles with start=1, op=1 -> hi=lo=0, busy=0; release, then drive reset=0 mid-MULT -> busy=0 and hi=lo=0 on the next cycle, no later commit.
- MULT latency (defaults): op1=0xFFFFFFFE (-2), op2=3 issued at T -> busy=1 for T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- MULTU: op1=op2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
- DIV signs: DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 0xFFFFFFF9/2 -> lo=0x7FFFFFFC, hi=1. Each takes 10 busy cycles.
- Divide edge cases:
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
  - Preload hi=0x11, lo=0x22 via MTHI/MTLO, then DIVU x/0 -> busy for 10 cycles, then hi=0x11, lo=0x22.
- Ignore-while-busy and MT timing:
  - During a MULT, assert start with op=5, op1=0xAA -> hi equals the product, not 0xAA.
  - With busy=0, MTLO 0x1234 -> lo=0x1234 next cycle, busy stays 0.
  - Re-run the MULT test with WIDTH=8, MULT_CYCLES=1: 0xFE*0x03 signed -> hi=0xFF, lo=0xFA, busy high for exactly one cycle.
